// File: rtl/alu_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default datapath width.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift the {remainder, dividend} pair left,
// trial-subtract the divisor and select the next quotient bit.
module alu_div_step
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   logic           fits;

   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      trial   = shifted - {1'b0, divisor};
      // rem_in < divisor, so a set shifted MSB always fits; otherwise the borrow decides
      fits    = shifted[WIDTH] | ~trial[WIDTH];
      rem_out = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divider (div/divu), one quotient bit per cycle.
// Signed operation is compiled in only when ALU_DIV_SIGNED_EN is defined.
module alu_div_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned      CNT_W     = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             zero_q, zero_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] mag_a, mag_b;
   logic             neg_quo, neg_rem;
   logic [WIDTH-1:0] step_rem, step_quo;

`ifdef ALU_DIV_SIGNED_EN
   logic sgn_a, sgn_b;

   assign sgn_a   = is_signed & a[WIDTH-1];
   assign sgn_b   = is_signed & b[WIDTH-1];
   assign mag_a   = sgn_a ? -a : a;
   assign mag_b   = sgn_b ? -b : b;
   assign neg_quo = sgn_a ^ sgn_b;
   assign neg_rem = sgn_a;
`else
   logic unused_is_signed;

   assign unused_is_signed = is_signed;
   assign mag_a   = a;
   assign mag_b   = b;
   assign neg_quo = 1'b0;
   assign neg_rem = 1'b0;
`endif

   alu_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .divisor (dvs_q),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      zero_d      = zero_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      if (state_q == CALC) begin
         if (zero_q) begin
            // quo_q holds the raw dividend when the divisor is zero
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = quo_q;
            dbz_d       = 1'b1;
         end else if (cnt_q == LAST_ITER) begin
            state_d     = DONE;
            quotient_d  = neg_quo_q ? -quo_q : quo_q;
            remainder_d = neg_rem_q ? -rem_q : rem_q;
            dbz_d       = 1'b0;
         end else begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 1'b1;
         end
      end else if (start) begin
         state_d   = CALC;
         cnt_d     = '0;
         rem_d     = '0;
         zero_d    = (b == '0);
         quo_d     = (b == '0) ? a : mag_a;
         dvs_d     = mag_b;
         neg_quo_d = neg_quo;
         neg_rem_d = neg_rem;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         zero_q      <= 1'b0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         zero_q      <= zero_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy        = (state_q == CALC);
   assign done        = (state_q == DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule
